// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
//   Shared types and constants for the SS.CC BCD stopwatch.
//   - sw_state_e            : control FSM state encoding (IDLE / RUN / PAUSE)
//   - DIGIT_MAX             : terminal value of a decimal digit (9)
//   - SEC_TENS_MAX_DEFAULT  : default terminal value of the seconds-tens digit
//   - NUM_DIGITS            : number of displayed digits
// ---------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    localparam logic [3:0] DIGIT_MAX            = 4'd9;
    localparam int         SEC_TENS_MAX_DEFAULT = 5;
    localparam int         NUM_DIGITS           = 4;

endpackage

// File: rtl/stopwatch_bcd_if.sv
// ---------------------------------------------------------------------------
// stopwatch_bcd_if
//   Bundles the stopwatch control inputs and display outputs.
//   Control (driven by master):  clk_div_in, start_stop, lap, clear
//   Display (driven by slave):   sec_tens, sec_ones, csec_tens, csec_ones,
//                                running, lap_active, wrap
//   modport master : upstream control logic / display consumer
//   modport slave  : the stopwatch itself
// ---------------------------------------------------------------------------
interface stopwatch_bcd_if;

    logic       clk_div_in;
    logic       start_stop;
    logic       lap;
    logic       clear;

    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] csec_tens;
    logic [3:0] csec_ones;
    logic       running;
    logic       lap_active;
    logic       wrap;

    modport master (
        output clk_div_in, start_stop, lap, clear,
        input  sec_tens, sec_ones, csec_tens, csec_ones,
        input  running, lap_active, wrap
    );

    modport slave (
        input  clk_div_in, start_stop, lap, clear,
        output sec_tens, sec_ones, csec_tens, csec_ones,
        output running, lap_active, wrap
    );

endinterface

// File: rtl/bcd_digit_cnt.sv
// ---------------------------------------------------------------------------
// bcd_digit_cnt
//   One mod-(MAX+1) BCD digit with ripple carry.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr_i      : synchronous clear to 0 (wins over counting)
//     en_i       : count-event qualifier shared by the whole digit chain
//     cin_i      : carry in from the lower digit (tie high for the LSD)
//     q_o        : current digit value
//     cout_o     : carry out, high when this digit is about to roll over
// ---------------------------------------------------------------------------
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       cin_i,
    output logic [3:0] q_o,
    output logic       cout_o
);

    logic [3:0] q_q;
    logic [3:0] q_d;
    logic       at_max;

    // >= rather than == so an out-of-range value can only ever fall back to 0.
    assign at_max = (q_q >= MAX);

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = 4'd0;
        end else if (en_i && cin_i) begin
            q_d = at_max ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o    = q_q;
    assign cout_o = cin_i && at_max;

endmodule

// File: rtl/stopwatch_bcd.sv
// ---------------------------------------------------------------------------
// stopwatch_bcd
//   SS.CC BCD stopwatch counting rising edges of an external divided clock.
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : stopwatch_bcd_if.slave
//             in : clk_div_in (async count events), start_stop, lap, clear
//                  (one-cycle pulses)
//             out: sec_tens/sec_ones/csec_tens/csec_ones (BCD display),
//                  running, lap_active, wrap (one-cycle rollover pulse)
//   Parameters:
//     SYNC_STAGES  : synchroniser depth on clk_div_in (2..3)
//     SEC_TENS_MAX : terminal value of the seconds-tens digit
// ---------------------------------------------------------------------------
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    stopwatch_bcd_if.slave  bus
);

    // ---------------- synchroniser + rising-edge detector ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   edge_q;
    logic                   tick;

    assign sync_d[0] = bus.clk_div_in;

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] && !edge_q;

    // ---------------- digit chain ----------------
    sw_state_e                  state_q;
    logic                       running_q;
    logic                       lap_active_q;
    logic                       wrap_q;
    logic [NUM_DIGITS-1:0][3:0] cnt;       // [0]=csec_ones ... [3]=sec_tens
    logic [NUM_DIGITS-1:0][3:0] lap_cap_q;
    logic [NUM_DIGITS:0]        carry;
    logic                       tick_en;
    logic                       cnt_clr;

    // Qualified by the pre-update state: a tick arriving with a stop pulse
    // is still counted, one arriving with a start pulse is not.
    assign tick_en  = tick && (state_q == ST_RUN);
    assign cnt_clr  = bus.clear && (state_q != ST_RUN);
    assign carry[0] = 1'b1;

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam logic [3:0] LIM = (gi == NUM_DIGITS - 1) ?
                                         4'(SEC_TENS_MAX) : DIGIT_MAX;
            bcd_digit_cnt #(
                .MAX (LIM)
            ) u_digit (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr_i  (cnt_clr),
                .en_i   (tick_en),
                .cin_i  (carry[gi]),
                .q_o    (cnt[gi]),
                .cout_o (carry[gi+1])
            );
        end
    endgenerate

    // ---------------- control FSM + lap capture ----------------
    // Priority within one cycle: clear > start_stop > lap. In RUN clear is
    // ignored, so start_stop/lap are still evaluated there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
            wrap_q       <= 1'b0;
            lap_cap_q    <= '0;
        end else begin
            // carry out of the top digit on a counted tick == rollover to 00.00
            wrap_q <= tick_en && carry[NUM_DIGITS];
            unique case (state_q)
                ST_RUN: begin
                    if (bus.start_stop) begin
                        state_q   <= ST_PAUSE;
                        running_q <= 1'b0;
                    end else if (bus.lap) begin
                        if (lap_active_q) begin
                            lap_active_q <= 1'b0;
                        end else begin
                            lap_cap_q    <= cnt;
                            lap_active_q <= 1'b1;
                        end
                    end
                end
                ST_IDLE, ST_PAUSE: begin
                    if (bus.clear) begin
                        state_q      <= ST_IDLE;
                        running_q    <= 1'b0;
                        lap_active_q <= 1'b0;
                        lap_cap_q    <= '0;
                    end else if (bus.start_stop) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else if (bus.lap && (state_q == ST_PAUSE)) begin
                        lap_active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    running_q    <= 1'b0;
                    lap_active_q <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    // Both sources are registers, so the live path adds no latency.
    logic [NUM_DIGITS-1:0][3:0] disp;

    assign disp           = lap_active_q ? lap_cap_q : cnt;
    assign bus.csec_ones  = disp[0];
    assign bus.csec_tens  = disp[1];
    assign bus.sec_ones   = disp[2];
    assign bus.sec_tens   = disp[3];
    assign bus.running    = running_q;
    assign bus.lap_active = lap_active_q;
    assign bus.wrap       = wrap_q;

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops on clk_div_in (legal values 2..3).
REQ-002 Parameter SEC_TENS_MAX, default 5: terminal value of the seconds-tens digit.
REQ-003 clk  input  1  system clock, rising-edge active.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clk_div_in  input  1  divided clock from the upstream frequency divider; each rising edge is one counting event.
REQ-006 start_stop  input  1  one-cycle pulse from upstream one-pulse logic; toggles run/pause.
REQ-007 lap  input  1  one-cycle pulse; freezes or releases the displayed value.
REQ-008 clear  input  1  one-cycle pulse; returns to zero when not running.
REQ-009 sec_tens, sec_ones, csec_tens, csec_ones  output  4 each  displayed BCD digits, SS.CC.
REQ-010 running  output  1  high while in RUN.
REQ-011 lap_active  output  1  high while the display is frozen.
REQ-012 wrap  output  1  one-cycle pulse when the count rolls from max to 00.00.

Function
REQ-013 clk_div_in shall pass through SYNC_STAGES flops, then a rising-edge detector, to produce a one-cycle tick.
REQ-014 With SYNC_STAGES=2, the internal count shall change on the 3rd rising clk edge after a setup-meeting rising edge of clk_div_in.
REQ-015 The FSM shall have states IDLE, RUN and PAUSE.
REQ-016 IDLE + start_stop -> RUN; RUN + start_stop -> PAUSE; PAUSE + start_stop -> RUN.
REQ-017 In IDLE or PAUSE, clear shall go to IDLE, zero the count and drop lap_active; in RUN, clear shall be ignored.
REQ-018 Input priority in the same cycle shall be clear > start_stop > lap.
REQ-019 A tick shall increment the count only when the current (pre-update) state is RUN: a tick coinciding with a stop pulse in RUN is counted, and a tick coinciding with a start pulse is not.
REQ-020 Digit ranges: csec_ones 0-9, csec_tens 0-9, sec_ones 0-9, sec_tens 0-SEC_TENS_MAX, with ripple carry between digits.
REQ-021 A tick at 59.99 shall give 00.00, assert wrap for exactly that update cycle, and keep RUN.
REQ-022 lap in RUN with lap_active=0 shall capture the count into a display register and set lap_active.
REQ-023 lap in RUN with lap_active=1 shall clear lap_active.
REQ-024 lap in PAUSE shall clear lap_active; lap in IDLE shall be ignored.
REQ-025 While lap_active=1, the outputs shall show the captured value and the internal count shall keep advancing.
REQ-026 While lap_active=0, the outputs shall show the live count registered, with zero added latency versus the count register.
REQ-027 The digits shall never hold a non-BCD value.

Reset
REQ-028 Asserting rst_n low shall, at any time and asynchronously, set state IDLE, all digits 0, the capture register 0, and running, lap_active and wrap to 0.
REQ-029 All synchroniser and edge-detector flops shall reset to 0.
REQ-030 A clk_div_in that is high at reset release may produce one tick; in IDLE this tick has no effect.

Structure
REQ-031 Package stopwatch_pkg shall hold the state encoding type and the digit terminal constants (9, SEC_TENS_MAX default).
REQ-032 Sub-module bcd_digit_cnt (mod-N BCD digit with en/carry-in, carry-out, sync clear) shall be instantiated four times.
REQ-033 The synchroniser, edge detector, FSM and lap register shall be in the top level.

Verification
REQ-034 Reset, then start_stop, then 150 clk_div_in edges -> display 01.50, running=1, wrap=0.
REQ-035 Run to 59.98, then 2 edges -> 59.99 then 00.00, wrap high for exactly one clk cycle, running stays 1.
REQ-036 At 00.20, lap; then 30 edges -> outputs hold 00.20 and lap_active=1; lap again -> outputs 00.50 on the next cycle.
REQ-037 In RUN, clear -> ignored; start_stop plus a tick in the same cycle -> PAUSE and count +1; clear -> 00.00, IDLE.
REQ-038 clear, start_stop and lap together in PAUSE -> IDLE, 00.00, lap_active=0.
REQ-039 rst_n pulled low mid-count at 12.34 -> all outputs 0 immediately, without waiting for a clk edge.
